pipelined_cla_adder: RTL

- Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready stream interface.
- The N-bit operation is split into GROUP-bit lookahead groups, one group per pipeline stage. Carry ripples stage-to-stage through registers; operands are skewed through the pipe.
- Sustains one operation per clock at full width where a single-cycle N-bit lookahead would not close timing.
- Sits between operand producers and result consumers in the datapath.

---
 rtl/cla_pkg.sv | 22 ++
 rtl/cla_group.sv | 46 ++++
 rtl/pipelined_cla_adder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
// The stage control flags are common to every width; the full stage record
// (which also needs the operand width) is built on top of them in the adder.
package cla_pkg;

  localparam int DEFAULT_GROUP = 4;

  // One pipeline stage per lookahead group.
  function automatic int stage_count(input int n, input int group);
    return n / group;
  endfunction

  // Per-stage control flags that travel alongside the data slices.
  typedef struct packed {
    logic valid;   // stage holds a live beat
    logic carry;   // carry out of the groups resolved so far
    logic ovf;     // signed overflow of the sum resolved so far
    logic sign_a;  // A[N-1], kept for the final overflow decision
    logic sign_b;  // Bop[N-1], kept for the final overflow decision
  } stage_ctl_t;

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead slice.
// Every internal carry is formed from the group-prefix generate/propagate
// terms and the group carry-in, so no carry ripples bit to bit.
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = DEFAULT_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             g,
  output logic             p
);

  logic [GROUP-1:0] gen;
  logic [GROUP-1:0] prop;
  logic [GROUP-1:0] gg;   // generate of bits i..0
  logic [GROUP-1:0] pp;   // propagate of bits i..0
  logic [GROUP:0]   c;

  assign gen   = a & b;
  assign prop  = a ^ b;
  assign gg[0] = gen[0];
  assign pp[0] = prop[0];
  assign c[0]  = cin;

  genvar gi;
  generate
    for (gi = 1; gi < GROUP; gi++) begin : g_prefix
      assign gg[gi] = gen[gi] | (prop[gi] & gg[gi-1]);
      assign pp[gi] = prop[gi] & pp[gi-1];
    end
    for (gi = 0; gi < GROUP; gi++) begin : g_carry
      assign c[gi+1] = gg[gi] | (pp[gi] & cin);
    end
  endgenerate

  assign sum  = prop ^ c[GROUP-1:0];
  assign cout = c[GROUP];
  assign g    = gg[GROUP-1];
  assign p    = pp[GROUP-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready stream.
// Stage k resolves bits (k+1)*GROUP-1 : k*GROUP; the carry between groups is
// registered, and the unresolved operand bits are shifted down one group per
// stage so every stage always works on the low GROUP bits of its remainder.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int N     = 16,
  parameter int GROUP = DEFAULT_GROUP
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         CIN,
  input  logic         SUB,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [N:0]   RESULT,
  output logic         OVF
);

  localparam int STAGES = stage_count(N, GROUP);

  typedef struct packed {
    stage_ctl_t   ctl;
    logic [N-1:0] sum;    // sum bits resolved so far
    logic [N-1:0] a_rem;  // unresolved A bits, next group in the low bits
    logic [N-1:0] b_rem;  // unresolved Bop bits, next group in the low bits
  } stage_t;

  stage_t stage_reg  [STAGES];
  stage_t stage_in   [STAGES];  // what each stage consumes this cycle
  stage_t stage_next [STAGES];  // what each stage would capture

  logic [GROUP-1:0] grp_sum [STAGES];
  logic             grp_cout [STAGES];
  // Group generate/propagate matter only for a second lookahead level; with
  // one group resolved per stage the registered carry is the group carry-out.
  logic             grp_g_unused [STAGES];
  logic             grp_p_unused [STAGES];

  logic         adv;
  logic [N-1:0] b_op;
  logic         c0;

  assign adv      = !stage_reg[STAGES-1].ctl.valid || OUT_READY;
  assign IN_READY = adv;
  assign b_op     = SUB ? ~B : B;
  assign c0       = SUB ? 1'b1 : CIN;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      stage_t           cur;
      stage_t           nxt;
      logic [N-1:0]     sum_acc;

      if (gi == 0) begin : g_first
        // Stage 0 takes its operands straight from the input beat.
        always_comb begin
          cur            = '0;
          cur.ctl.valid  = IN_VALID;
          cur.ctl.carry  = c0;
          cur.ctl.sign_a = A[N-1];
          cur.ctl.sign_b = b_op[N-1];
          cur.a_rem      = A;
          cur.b_rem      = b_op;
        end
      end else begin : g_rest
        assign cur = stage_reg[gi-1];
      end

      assign stage_in[gi] = cur;

      cla_group #(.GROUP(GROUP)) u_group (
        .a    (cur.a_rem[GROUP-1:0]),
        .b    (cur.b_rem[GROUP-1:0]),
        .cin  (cur.ctl.carry),
        .sum  (grp_sum[gi]),
        .cout (grp_cout[gi]),
        .g    (grp_g_unused[gi]),
        .p    (grp_p_unused[gi])
      );

      // Fold this group's sum in, pass the carry on, shift the operands down.
      always_comb begin
        sum_acc                        = cur.sum;
        sum_acc[gi*GROUP +: GROUP]     = grp_sum[gi];
        nxt                            = cur;
        nxt.sum                        = sum_acc;
        nxt.a_rem                      = cur.a_rem >> GROUP;
        nxt.b_rem                      = cur.b_rem >> GROUP;
        nxt.ctl.carry                  = grp_cout[gi];
        nxt.ctl.ovf                    = (cur.ctl.sign_a == cur.ctl.sign_b) &&
                                         (sum_acc[N-1] != cur.ctl.sign_a);
      end

      assign stage_next[gi] = nxt;
    end
  endgenerate

  // Whole pipe shifts together on adv; bubbles clear only the valid bit so
  // stale data (and hence RESULT) holds during idle cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_reg[i] <= '0;
      end
    end else if (adv) begin
      for (int i = 0; i < STAGES; i++) begin
        if (stage_in[i].ctl.valid) begin
          stage_reg[i] <= stage_next[i];
        end else begin
          stage_reg[i].ctl.valid <= 1'b0;
        end
      end
    end
  end

  assign OUT_VALID = stage_reg[STAGES-1].ctl.valid;
  assign RESULT    = {stage_reg[STAGES-1].ctl.carry, stage_reg[STAGES-1].sum};
  assign OVF       = stage_reg[STAGES-1].ctl.ovf;

endmodule
